// File: rtl/itlb_refill_ctrl.sv
// I-TLB refill sequencer: miss -> L2 TLB query -> victim selection -> slot write, plus INVTLB pulse.
// Optional ITLB_PERF_CNT_EN adds perf_miss_cnt / perf_stall_cnt outputs.
module itlb_refill_ctrl #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5,
  parameter int VPN_W   = 20,
  parameter int ASID_W  = 10,
  parameter int ENTRY_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [VPN_W-1:0]   miss_vpn,
  input  logic [ASID_W-1:0]  miss_asid,
  input  logic               flush,
  input  logic               inv_all,
  input  logic [ENTRIES-1:0] valid_vec,
  output logic               l2_req_valid,
  input  logic               l2_req_ready,
  output logic [VPN_W-1:0]   l2_req_vpn,
  output logic [ASID_W-1:0]  l2_req_asid,
  input  logic               l2_resp_valid,
  input  logic               l2_resp_hit,
  input  logic [ENTRY_W-1:0] l2_resp_entry,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_idx,
  output logic [ENTRY_W-1:0] wr_entry,
  output logic               inv_en,
  output logic               refill_done,
  output logic               refill_fault,
  output logic               busy
`ifdef ITLB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_miss_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [ASID_W-1:0]  asid_q, asid_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [IDX_W-1:0]   victim_q, victim_d;
  logic               rr_used_q, rr_used_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               fault_q, fault_d;
  logic               inv_q;
  logic               abort;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;

  assign abort = flush | inv_all;

  // Lowest-index free slot; the descending loop lets the smallest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    vpn_d     = vpn_q;
    asid_d    = asid_q;
    entry_d   = entry_q;
    victim_d  = victim_q;
    rr_used_d = rr_used_q;
    fault_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_valid && miss_ready) begin
          vpn_d   = miss_vpn;
          asid_d  = miss_asid;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A request accepted together with an abort still owes us one response.
        if (l2_req_ready) state_d = abort ? S_DROP : S_WAIT;
        else if (abort)   state_d = S_IDLE;
      end
      S_WAIT: begin
        if (l2_resp_valid) begin
          if (abort) begin
            state_d = S_IDLE;
          end else if (l2_resp_hit) begin
            entry_d   = l2_resp_entry;
            victim_d  = free_found ? free_idx : rr_q;
            rr_used_d = !free_found;
            state_d   = S_FILL;
          end else begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (abort) begin
          state_d = S_DROP;
        end
      end
      S_FILL: state_d = S_IDLE;
      S_DROP: if (l2_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rr_d = (wr_en && rr_used_q) ? rr_q + 1'b1 : rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vpn_q     <= '0;
      asid_q    <= '0;
      entry_q   <= '0;
      victim_q  <= '0;
      rr_used_q <= 1'b0;
      rr_q      <= '0;
      fault_q   <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vpn_q     <= vpn_d;
      asid_q    <= asid_d;
      entry_q   <= entry_d;
      victim_q  <= victim_d;
      rr_used_q <= rr_used_d;
      rr_q      <= rr_d;
      fault_q   <= fault_d;
      inv_q     <= inv_all;
    end
  end

  assign miss_ready   = (state_q == S_IDLE) && !inv_all && !flush;
  assign l2_req_valid = (state_q == S_REQ);
  assign l2_req_vpn   = vpn_q;
  assign l2_req_asid  = asid_q;
  assign wr_en        = (state_q == S_FILL) && !inv_all;
  assign refill_done  = wr_en;
  assign wr_idx       = victim_q;
  assign wr_entry     = entry_q;
  assign inv_en       = inv_q;
  assign refill_fault = fault_q;
  assign busy         = (state_q != S_IDLE);

`ifdef ITLB_PERF_CNT_EN
  logic [31:0] miss_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (miss_valid && miss_ready) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (busy)                     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_miss_cnt  = miss_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
